// File: rtl/instr_dispatch_ctrl_if.sv
// Bus bundle between the instruction sequencer and its environment:
// fetch handshake, execution-unit start/done, bus drive enables and status.
interface instr_dispatch_ctrl_if;
    logic        run;
    logic        clear_fault;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic [3:0]  done;
    logic [7:0]  bus_oe;
    logic        fetch_req;
    logic [15:0] ir;
    logic [3:0]  start;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic        bus_conflict;
    logic [15:0] instr_count;

    modport master (
        output run, clear_fault, instr_in, instr_valid, done, bus_oe,
        input  fetch_req, ir, start, busy, halted, fault, fault_code,
               bus_conflict, instr_count
    );

    modport slave (
        input  run, clear_fault, instr_in, instr_valid, done, bus_oe,
        output fetch_req, ir, start, busy, halted, fault, fault_code,
               bus_conflict, instr_count
    );
endinterface

// File: rtl/instr_dispatch_ctrl.sv
// Instruction sequencer: fetches a word, decodes opcode [15:12], starts one
// execution unit via start/done, retires and counts instructions. Polices the
// shared bus for multiple drivers and times out memory and execution waits.
module instr_dispatch_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_dispatch_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_DECODE,
        S_EXEC,
        S_RETIRE,
        S_HALTED,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        FC_BUS      = 2'b00,
        FC_ILLEGAL  = 2'b01,
        FC_SPURIOUS = 2'b10,
        FC_TIMEOUT  = 2'b11
    } fcode_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    fcode_t      fcode_q, fcode_d;
    logic [1:0]  unit_q, unit_d;
    logic [7:0]  wdog_q;
    logic [15:0] ir_q;
    logic [15:0] count_q;
    logic [3:0]  start_q;
    logic        fetch_q;
    logic        busy_q;
    logic        halted_q;
    logic        fault_q;
    logic        conflict_q;

    logic        wd_expired;
    logic        multi_drive;
    logic        dec_nop;
    logic        dec_halt;
    logic        dec_legal;
    logic [1:0]  dec_unit;

    assign wd_expired  = (wdog_q == WD_LAST);
    assign multi_drive = |(bus.bus_oe & (bus.bus_oe - 8'd1));

    // Opcode classification of the held instruction register.
    always_comb begin
        dec_nop   = 1'b0;
        dec_halt  = 1'b0;
        dec_legal = 1'b1;
        dec_unit  = 2'd0;
        case (ir_q[15:12])
            4'h0:             dec_nop  = 1'b1;
            4'h1, 4'h2:       dec_unit = 2'd1;
            4'h3, 4'h4, 4'h5: dec_unit = 2'd2;
            4'h6, 4'h7:       dec_unit = 2'd0;
            4'h8, 4'h9:       dec_unit = 2'd3;
            4'hF:             dec_halt = 1'b1;
            default:          dec_legal = 1'b0;
        endcase
    end

    // Next-state, fault code and selected unit.
    always_comb begin
        state_d = state_q;
        fcode_d = fcode_q;
        unit_d  = unit_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (bus.instr_valid) begin
                    state_d = S_DECODE;
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_nop) begin
                    state_d = S_RETIRE;
                end else if (dec_halt) begin
                    state_d = S_HALTED;
                end else if (!dec_legal) begin
                    state_d = S_FAULT;
                    fcode_d = FC_ILLEGAL;
                end else begin
                    unit_d  = dec_unit;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (conflict_q) begin
                    state_d = S_FAULT;
                    fcode_d = FC_BUS;
                end else if (bus.done[unit_q]) begin
                    state_d = S_RETIRE;
                end else if (|bus.done) begin
                    state_d = S_FAULT;
                    fcode_d = FC_SPURIOUS;
                end else if (wd_expired) begin
                    state_d = S_FAULT;
                    fcode_d = FC_TIMEOUT;
                end
            end
            S_RETIRE: begin
                state_d = bus.run ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            S_FAULT: begin
                if (bus.clear_fault) begin
                    state_d = S_IDLE;
                    fcode_d = FC_BUS;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and Moore outputs, registered from the next state so
    // each output lines up with the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fcode_q  <= FC_BUS;
            unit_q   <= 2'd0;
            fetch_q  <= 1'b0;
            start_q  <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcode_q  <= fcode_d;
            unit_q   <= unit_d;
            fetch_q  <= (state_d == S_FETCH);
            start_q  <= (state_q == S_DECODE && state_d == S_EXEC) ? (4'b0001 << unit_d) : '0;
            busy_q   <= !(state_d inside {S_IDLE, S_HALTED, S_FAULT});
            halted_q <= (state_d == S_HALTED);
            fault_q  <= (state_d == S_FAULT);
        end
    end

    // Instruction register loads on the accepted memory beat only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q <= '0;
        end else if (state_q == S_WAIT_MEM && bus.instr_valid) begin
            ir_q <= bus.instr_in;
        end
    end

    // Retired-instruction counter, bumped on entry to RETIRE; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_d == S_RETIRE) begin
            count_q <= count_q + 16'd1;
        end
    end

    // Watchdog: zero on entering any state, counts while waiting on memory or a unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else if (state_d != state_q) begin
            wdog_q <= '0;
        end else if (state_q == S_WAIT_MEM || state_q == S_EXEC) begin
            wdog_q <= wdog_q + 8'd1;
        end
    end

    // Bus multiple-driver flag, one cycle behind the drive enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= multi_drive;
        end
    end

    assign bus.fetch_req    = fetch_q;
    assign bus.ir           = ir_q;
    assign bus.start        = start_q;
    assign bus.busy         = busy_q;
    assign bus.halted       = halted_q;
    assign bus.fault        = fault_q;
    assign bus.fault_code   = fcode_q;
    assign bus.bus_conflict = conflict_q;
    assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
module tb_instr_dispatch_ctrl;

  localparam int T = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_count = '0;

  instr_dispatch_ctrl_if bus_if();

  instr_dispatch_ctrl #(.TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic int unit_for(input logic [15:0] w);
    case (w[15:12])
      4'h0:             return -1;
      4'h1, 4'h2:       return 1;
      4'h3, 4'h4, 4'h5: return 2;
      4'h6, 4'h7:       return 0;
      4'h8, 4'h9:       return 3;
      4'hF:             return -2;
      default:          return -3;
    endcase
  endfunction

  function automatic void predict_exec(input int unit, input int done_dly,
                                       input logic [3:0] done_bits, input int cf,
                                       output int end_c, output int outcome);
    int t_cf, t_dn;
    t_cf    = (cf >= 0) ? cf + 1 : 1 << 20;
    t_dn    = (done_bits != 4'b0000) ? done_dly : 1 << 20;
    end_c   = T - 1;
    outcome = 3;
    if (t_dn <= end_c) begin
      end_c   = t_dn;
      outcome = done_bits[unit] ? 4 : 2;
    end
    if (t_cf <= end_c) begin
      end_c   = t_cf;
      outcome = 0;
    end
  endfunction

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_if.fetch_req !== 1'b0) begin errors++; $error("FAIL rst_fetch_req: got %0h, expected %0h", bus_if.fetch_req, 1'b0); end
    checks++;
    if (bus_if.start !== 4'b0000) begin errors++; $error("FAIL rst_start: got %0h, expected %0h", bus_if.start, 4'b0000); end
    checks++;
    if (bus_if.ir !== 16'h0000) begin errors++; $error("FAIL rst_ir: got %0h, expected %0h", bus_if.ir, 16'h0000); end
    checks++;
    if (bus_if.busy !== 1'b0) begin errors++; $error("FAIL rst_busy: got %0h, expected %0h", bus_if.busy, 1'b0); end
    checks++;
    if (bus_if.halted !== 1'b0) begin errors++; $error("FAIL rst_halted: got %0h, expected %0h", bus_if.halted, 1'b0); end
    checks++;
    if (bus_if.fault !== 1'b0) begin errors++; $error("FAIL rst_fault: got %0h, expected %0h", bus_if.fault, 1'b0); end
    checks++;
    if (bus_if.fault_code !== 2'b00) begin errors++; $error("FAIL rst_fault_code: got %0h, expected %0h", bus_if.fault_code, 2'b00); end
    checks++;
    if (bus_if.bus_conflict !== 1'b0) begin errors++; $error("FAIL rst_bus_conflict: got %0h, expected %0h", bus_if.bus_conflict, 1'b0); end
    checks++;
    if (bus_if.instr_count !== 16'h0000) begin errors++; $error("FAIL rst_instr_count: got %0h, expected %0h", bus_if.instr_count, 16'h0000); end
    exp_count = '0;
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0) begin errors++; $error("FAIL rst_hold_busy: got %0h, expected %0h", bus_if.busy, 1'b0); end
    rst = 1'b0;
  endtask

  task automatic check_retire(input logic [15:0] word);
    exp_count = exp_count + 16'd1;
    checks++;
    if (bus_if.busy !== 1'b1) begin errors++; $error("FAIL retire_busy: got %0h, expected %0h", bus_if.busy, 1'b1); end
    checks++;
    if (bus_if.instr_count !== exp_count) begin errors++; $error("FAIL retire_count: got %0h, expected %0h", bus_if.instr_count, exp_count); end
    checks++;
    if (bus_if.ir !== word) begin errors++; $error("FAIL retire_ir: got %0h, expected %0h", bus_if.ir, word); end
    checks++;
    if (bus_if.start !== 4'b0000) begin errors++; $error("FAIL retire_start: got %0h, expected %0h", bus_if.start, 4'b0000); end
    checks++;
    if (bus_if.fault !== 1'b0) begin errors++; $error("FAIL retire_fault: got %0h, expected %0h", bus_if.fault, 1'b0); end
    @(negedge clk);
    if (bus_if.run) begin
      checks++;
      if (bus_if.fetch_req !== 1'b1) begin errors++; $error("FAIL next_fetch_req: got %0h, expected %0h", bus_if.fetch_req, 1'b1); end
    end else begin
      checks++;
      if (bus_if.fetch_req !== 1'b0) begin errors++; $error("FAIL idle_fetch_req: got %0h, expected %0h", bus_if.fetch_req, 1'b0); end
      checks++;
      if (bus_if.busy !== 1'b0) begin errors++; $error("FAIL idle_busy: got %0h, expected %0h", bus_if.busy, 1'b0); end
    end
  endtask

  task automatic expect_fault(input logic [1:0] code);
    checks++;
    if (bus_if.fault !== 1'b1) begin errors++; $error("FAIL fault_flag: got %0h, expected %0h", bus_if.fault, 1'b1); end
    checks++;
    if (bus_if.fault_code !== code) begin errors++; $error("FAIL fault_code: got %0h, expected %0h", bus_if.fault_code, code); end
    checks++;
    if (bus_if.busy !== 1'b0) begin errors++; $error("FAIL fault_busy: got %0h, expected %0h", bus_if.busy, 1'b0); end
    checks++;
    if (bus_if.start !== 4'b0000) begin errors++; $error("FAIL fault_start: got %0h, expected %0h", bus_if.start, 4'b0000); end
    checks++;
    if (bus_if.halted !== 1'b0) begin errors++; $error("FAIL fault_halted: got %0h, expected %0h", bus_if.halted, 1'b0); end
    repeat (2) begin
      bus_if.done = 4'($urandom);
      @(negedge clk);
      checks++;
      if (bus_if.fault !== 1'b1) begin errors++; $error("FAIL fault_hold: got %0h, expected %0h", bus_if.fault, 1'b1); end
      checks++;
      if (bus_if.fault_code !== code) begin errors++; $error("FAIL fault_code_hold: got %0h, expected %0h", bus_if.fault_code, code); end
    end
    bus_if.done        = '0;
    bus_if.clear_fault = 1'b1;
    @(negedge clk);
    bus_if.clear_fault = 1'b0;
    checks++;
    if (bus_if.fault !== 1'b0) begin errors++; $error("FAIL clr_fault: got %0h, expected %0h", bus_if.fault, 1'b0); end
    checks++;
    if (bus_if.fault_code !== 2'b00) begin errors++; $error("FAIL clr_fault_code: got %0h, expected %0h", bus_if.fault_code, 2'b00); end
    checks++;
    if (bus_if.busy !== 1'b0) begin errors++; $error("FAIL clr_busy: got %0h, expected %0h", bus_if.busy, 1'b0); end
    if (bus_if.run) begin
      @(negedge clk);
      checks++;
      if (bus_if.fetch_req !== 1'b1) begin errors++; $error("FAIL clr_next_fetch: got %0h, expected %0h", bus_if.fetch_req, 1'b1); end
    end
  endtask

  task automatic do_instr(input logic [15:0] word, input int mem_dly,
                          input int done_dly, input logic [3:0] done_bits,
                          input int cf, input bit drop_run, input int rst_at);
    int k, unit, end_c, outc;
    logic [7:0] oe;
    logic [3:0] exp_start;
    logic       exp_cf;
    checks++;
    if (bus_if.fetch_req !== 1'b1) begin errors++; $error("FAIL fetch_req: got %0h, expected %0h", bus_if.fetch_req, 1'b1); end
    checks++;
    if (bus_if.busy !== 1'b1) begin errors++; $error("FAIL fetch_busy: got %0h, expected %0h", bus_if.busy, 1'b1); end
    bus_if.done   = 4'($urandom);
    bus_if.bus_oe = 8'($urandom);
    @(negedge clk);
    k  = 0;
    oe = '0;
    while (1) begin
      checks++;
      if (bus_if.busy !== 1'b1) begin errors++; $error("FAIL wait_busy: got %0h, expected %0h", bus_if.busy, 1'b1); end
      checks++;
      if (bus_if.fetch_req !== 1'b0) begin errors++; $error("FAIL wait_fetch_low: got %0h, expected %0h", bus_if.fetch_req, 1'b0); end
      checks++;
      if (bus_if.fault !== 1'b0) begin errors++; $error("FAIL wait_fault: got %0h, expected %0h", bus_if.fault, 1'b0); end
      oe            = 8'($urandom);
      bus_if.bus_oe = oe;
      bus_if.done   = 4'($urandom);
      if (k == mem_dly) begin
        bus_if.instr_valid = 1'b1;
        bus_if.instr_in    = word;
        @(negedge clk);
        bus_if.instr_valid = 1'b0;
        bus_if.instr_in    = 16'($urandom);
        break;
      end
      bus_if.instr_valid = 1'b0;
      bus_if.instr_in    = 16'($urandom);
      @(negedge clk);
      k++;
      if (k == T) break;
    end
    bus_if.bus_oe = '0;
    if (mem_dly >= T) begin
      bus_if.done = '0;
      expect_fault(2'b11);
      return;
    end
    checks++;
    if (bus_if.ir !== word) begin errors++; $error("FAIL decode_ir: got %0h, expected %0h", bus_if.ir, word); end
    checks++;
    if (bus_if.start !== 4'b0000) begin errors++; $error("FAIL decode_start: got %0h, expected %0h", bus_if.start, 4'b0000); end
    exp_cf = ($countones(oe) > 1) ? 1'b1 : 1'b0;
    checks++;
    if (bus_if.bus_conflict !== exp_cf) begin errors++; $error("FAIL decode_conflict: got %0h, expected %0h", bus_if.bus_conflict, exp_cf); end
    bus_if.done = 4'($urandom);
    if (drop_run) bus_if.run = 1'b0;
    unit = unit_for(word);
    @(negedge clk);
    bus_if.done = '0;
    if (unit == -2) begin
      checks++;
      if (bus_if.halted !== 1'b1) begin errors++; $error("FAIL halt_flag: got %0h, expected %0h", bus_if.halted, 1'b1); end
      checks++;
      if (bus_if.busy !== 1'b0) begin errors++; $error("FAIL halt_busy: got %0h, expected %0h", bus_if.busy, 1'b0); end
      checks++;
      if (bus_if.instr_count !== exp_count) begin errors++; $error("FAIL halt_count: got %0h, expected %0h", bus_if.instr_count, exp_count); end
      return;
    end
    if (unit == -3) begin
      expect_fault(2'b01);
      return;
    end
    if (unit == -1) begin
      check_retire(word);
      return;
    end
    predict_exec(unit, done_dly, done_bits, cf, end_c, outc);
    for (int unsigned j = 0; j <= end_c; j++) begin
      exp_start = (j == 0) ? (4'b0001 << unit) : 4'b0000;
      checks++;
      if (bus_if.busy !== 1'b1) begin errors++; $error("FAIL exec_busy: got %0h, expected %0h", bus_if.busy, 1'b1); end
      checks++;
      if (bus_if.start !== exp_start) begin errors++; $error("FAIL exec_start: got %0h, expected %0h", bus_if.start, exp_start); end
      checks++;
      if (bus_if.fault !== 1'b0) begin errors++; $error("FAIL exec_fault: got %0h, expected %0h", bus_if.fault, 1'b0); end
      if (cf >= 0 && j == cf + 1) begin
        checks++;
        if (bus_if.bus_conflict !== 1'b1) begin errors++; $error("FAIL exec_conflict: got %0h, expected %0h", bus_if.bus_conflict, 1'b1); end
      end
      if (rst_at >= 0 && j == rst_at) begin
        bus_if.done = 4'b0001 << unit;
        do_reset();
        @(negedge clk);
        checks++;
        if (bus_if.fault !== 1'b0) begin errors++; $error("FAIL post_rst_fault: got %0h, expected %0h", bus_if.fault, 1'b0); end
        checks++;
        if (bus_if.start !== 4'b0000) begin errors++; $error("FAIL post_rst_start: got %0h, expected %0h", bus_if.start, 4'b0000); end
        checks++;
        if (bus_if.instr_count !== exp_count) begin errors++; $error("FAIL post_rst_count: got %0h, expected %0h", bus_if.instr_count, exp_count); end
        checks++;
        if (bus_if.fetch_req !== 1'b1) begin errors++; $error("FAIL post_rst_fetch: got %0h, expected %0h", bus_if.fetch_req, 1'b1); end
        bus_if.done = '0;
        return;
      end
      bus_if.done   = (done_dly >= 0 && j == done_dly) ? done_bits : 4'b0000;
      bus_if.bus_oe = (cf >= 0 && j == cf) ? 8'h11 : 8'(1 << $urandom_range(0, 8));
      @(negedge clk);
    end
    bus_if.done   = '0;
    bus_if.bus_oe = '0;
    if (outc == 4) check_retire(word);
    else expect_fault(2'(outc));
  endtask

  initial begin
    int u, md, dd, cf;
    logic [15:0] w;
    logic [3:0]  bits;

    bus_if.run         = 1'b0;
    bus_if.clear_fault = 1'b0;
    bus_if.instr_in    = '0;
    bus_if.instr_valid = 1'b0;
    bus_if.done        = '0;
    bus_if.bus_oe      = '0;

    @(negedge clk);
    do_reset();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus_if.fetch_req !== 1'b0) begin errors++; $error("FAIL idle_no_fetch: got %0h, expected %0h", bus_if.fetch_req, 1'b0); end
      checks++;
      if (bus_if.busy !== 1'b0) begin errors++; $error("FAIL idle_not_busy: got %0h, expected %0h", bus_if.busy, 1'b0); end
    end
    bus_if.run = 1'b1;
    @(negedge clk);

    do_instr(16'h1083, 0, 8, 4'b0010, -1, 0, -1);

    do_reset();
    @(negedge clk);
    do_instr(16'h0000, 0, 0, 4'b0000, -1, 0, -1);
    do_instr(16'h0000, 1, 0, 4'b0000, -1, 0, -1);
    do_instr(16'hF000, 0, 0, 4'b0000, -1, 0, -1);
    checks++;
    if (bus_if.instr_count !== 16'd2) begin errors++; $error("FAIL halt_count_two: got %0h, expected %0h", bus_if.instr_count, 16'd2); end
    repeat (3) begin
      bus_if.clear_fault = 1'b1;
      bus_if.instr_valid = 1'b1;
      bus_if.done        = 4'($urandom);
      @(negedge clk);
      checks++;
      if (bus_if.halted !== 1'b1) begin errors++; $error("FAIL halted_hold: got %0h, expected %0h", bus_if.halted, 1'b1); end
      checks++;
      if (bus_if.busy !== 1'b0) begin errors++; $error("FAIL halted_busy: got %0h, expected %0h", bus_if.busy, 1'b0); end
      checks++;
      if (bus_if.fetch_req !== 1'b0) begin errors++; $error("FAIL halted_no_fetch: got %0h, expected %0h", bus_if.fetch_req, 1'b0); end
    end
    bus_if.clear_fault = 1'b0;
    bus_if.instr_valid = 1'b0;
    bus_if.done        = '0;
    do_reset();
    @(negedge clk);

    do_instr(16'hA000, 0, 0, 4'b0000, -1, 0, -1);
    do_instr(16'h3000, 0, 2, 4'b0001, -1, 0, -1);
    do_instr(16'h4000, 0, 0, 4'b0000, -1, 0, -1);
    do_instr(16'h5123, 0, T - 1, 4'b0100, -1, 0, -1);
    do_instr(16'h8000, 0, 5, 4'b1000, 1, 0, -1);
    do_instr(16'h1000, T, 0, 4'b0010, -1, 0, -1);
    do_instr(16'h2abc, T - 1, 0, 4'b0010, -1, 0, -1);

    do_instr(16'h6000, 1, 2, 4'b0001, -1, 1, -1);
    bus_if.run = 1'b1;
    @(negedge clk);

    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    exp_count = 16'hFFFF;
    do_instr(16'h0000, 0, 0, 4'b0000, -1, 0, -1);
    checks++;
    if (bus_if.instr_count !== 16'h0000) begin errors++; $error("FAIL wrap_count: got %0h, expected %0h", bus_if.instr_count, 16'h0000); end

    for (int unsigned n = 0; n < 40; n++) begin
      w  = {4'($urandom_range(0, 14)), 12'($urandom)};
      u  = unit_for(w);
      md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      dd = $urandom_range(0, 6);
      if (u >= 0 && $urandom_range(0, 3) != 0) bits = 4'b0001 << u;
      else bits = 4'($urandom_range(1, 15));
      cf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      do_instr(w, md, dd, bits, cf, 0, -1);
    end

    do_instr(16'h3000, 0, 20, 4'b0100, -1, 0, 3);
    do_instr(16'h9000, 0, 1, 4'b1000, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "bench did not complete");
  end

endmodule
